reg_alu_xfer: RTL
=================

REG_ALU_XFER -- requirements
Module: reg_alu_xfer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register and datapath width in bits (legal 2..16).
REQ-002 The block SHALL have parameter NREG, default 3, register count (legal 3..8); R[NREG-1] is the ALU result register.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port BTN_Y  input  NREG  raw per-register action buttons, level.
REQ-006 The block SHALL have port dir  input  NREG  per-register count direction: 0 = up, 1 = down.
REQ-007 The block SHALL have port alu_op  input  3  ALU operation select.
REQ-008 The block SHALL have port src_sel  input  $clog2(NREG+1)  transfer source: value k < NREG selects R[k]; value NREG selects constant 0.
REQ-009 The block SHALL have port mode  input  1  0 = ALU/count mode, 1 = transfer mode.
REQ-010 The block SHALL have port debug_reg  output  NREG*WIDTH  R[k] at bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port debug_res  output  WIDTH  (R[0]+R[1]) mod 2^WIDTH, combinational.
REQ-012 The block SHALL have port flags  output  2  {carry, zero}, latched on ALU writes only.
REQ-013 The block SHALL have port upd  output  1  one-cycle pulse, cycle after any register write.

Function
REQ-014 Each BTN_Y bit SHALL pass a rising-edge detector; one press SHALL produce exactly one action regardless of hold length.
REQ-015 Action latency SHALL be one cycle from detected edge to register update.
REQ-016 Mode 0, action k < NREG-1: R[k] SHALL increment (dir[k]=0) or decrement (dir[k]=1) modulo 2^WIDTH; F..F+1 = 0, 0-1 = F..F.
REQ-017 Mode 0, action NREG-1: R[NREG-1] SHALL load ALU(R[0],R[1]).
REQ-018 ALU ops SHALL be: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 A<<1, 110 A>>1 logical, 111 pass B; all truncated to WIDTH.
REQ-019 carry SHALL be: add carry-out, sub borrow (A<B), shifted-out bit for 101/110, 0 otherwise; zero SHALL be result==0.
REQ-020 Mode 1, action k: R[k] SHALL load source selected by src_sel; src_sel > NREG SHALL load 0.
REQ-021 Simultaneous actions SHALL update all targeted registers in the same cycle using pre-update values (e.g. R0<-R1 and R1<-R0 swap).
REQ-022 Self-transfer (src_sel == k) SHALL leave R[k] unchanged but still pulse upd.
REQ-023 mode, dir, alu_op, src_sel SHALL be sampled in the same cycle as the detected edge; changes between edges SHALL have no effect.
REQ-024 upd SHALL be 1 for exactly one cycle after any cycle with at least one action.

Reset
REQ-025 rst asserted SHALL immediately clear all R[k], flags, upd and edge-detector history to 0.
REQ-026 A button held through reset deassertion SHALL NOT generate an action until released and pressed again.
REQ-027 Reset mid-press SHALL abort the pending action; no register write SHALL occur.

Configuration
REQ-028 Macro REG_ALU_XFER_SYNC_EN defined: BTN_Y SHALL pass a 2-flop synchroniser before edge detection, action latency 3 cycles.
REQ-029 Macro REG_ALU_XFER_SYNC_EN undefined: BTN_Y SHALL feed edge detection directly, latency 1 cycle per REQ-015.

Structure
REQ-030 A shared package reg_alu_xfer_pkg SHALL hold the alu_op encodings and mode constants.
REQ-031 The ALU SHALL be a combinational sub-module alu_core (WIDTH param; ports a, b, op, result, carry).
REQ-032 Edge detection/synchronisation SHALL be in reg_alu_xfer; no other sub-modules.

Verification
REQ-033 WIDTH=4,NREG=3: press B0 once, B1 three times, B1 once with dir[1]=1 -> R0=1, R1=2, debug_res=3.
REQ-034 R0=1,R1=2: alu_op 000,001,010,011 each + B2 -> R2=3, F (carry=1), 0 (zero=1), 3.
REQ-035 R0=F,dir[0]=0, press B0 -> R0=0; R0=0,dir[0]=1, press B0 -> R0=F.
REQ-036 Mode 1, R0=3,R1=5, src_sel=1 press B0 and src_sel same cycle irrelevant for swap test: src_sel=3 (zero) press B1 -> R1=0, upd pulses once.
REQ-037 Hold B0 for 10 cycles -> one increment only; assert rst during hold, release rst with B0 held -> R0 stays 0.
REQ-038 WIDTH=8,NREG=5: R0=0x80, alu_op 101, press B4 -> R4=0x00, carry=1, zero=1.

Source files
------------

// File: rtl/reg_alu_xfer_pkg.sv
// Shared encodings for reg_alu_xfer: ALU operation codes and mode select values.
package reg_alu_xfer_pkg;

    typedef enum logic [2:0] {
        AluAdd   = 3'b000,
        AluSub   = 3'b001,
        AluAnd   = 3'b010,
        AluOr    = 3'b011,
        AluXor   = 3'b100,
        AluShl   = 3'b101,
        AluShr   = 3'b110,
        AluPassB = 3'b111
    } alu_op_e;

    localparam logic ModeAlu  = 1'b0;
    localparam logic ModeXfer = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for reg_alu_xfer; carry is carry-out, borrow, or the shifted-out bit.
module alu_core
    import reg_alu_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // Zero-extended subtraction: the top bit is set exactly when a < b.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(op))
            AluAdd: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
            AluSub: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
            end
            AluAnd:   result = a & b;
            AluOr:    result = a | b;
            AluXor:   result = a ^ b;
            AluShl: begin
                result = {a[WIDTH-2:0], 1'b0};
                carry  = a[WIDTH-1];
            end
            AluShr: begin
                result = {1'b0, a[WIDTH-1:1]};
                carry  = a[0];
            end
            AluPassB: result = b;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/reg_alu_xfer.sv
// Button-driven register file with count, ALU and transfer actions.
// Define REG_ALU_XFER_SYNC_EN to put a 2-flop synchroniser in front of edge detection.
module reg_alu_xfer
    import reg_alu_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREG  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREG-1:0]            BTN_Y,
    input  logic [NREG-1:0]            dir,
    input  logic [2:0]                 alu_op,
    input  logic [$clog2(NREG+1)-1:0]  src_sel,
    input  logic                       mode,
    output logic [NREG*WIDTH-1:0]      debug_reg,
    output logic [WIDTH-1:0]           debug_res,
    output logic [1:0]                 flags,
    output logic                       upd
);

    localparam int unsigned SelW = $clog2(NREG + 1);
    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [1:0]       flags_q, flags_d;
    logic             upd_q;

    logic [NREG-1:0]  btn;
    logic [NREG-1:0]  btn_prev_q;
    logic [NREG-1:0]  arm_q;
    logic [NREG-1:0]  act;
    logic             fill;

`ifdef REG_ALU_XFER_SYNC_EN
    logic [NREG-1:0] sync1_q, sync2_q;
    logic [1:0]      fill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= BTN_Y;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
        end
    end

    assign btn  = sync2_q;
    // Ignore the synchroniser's reset zeros until real button samples reach its output.
    assign fill = fill_q[1];
`else
    assign btn  = BTN_Y;
    assign fill = 1'b1;
`endif

    // A button is armed only once it has been seen released since reset, so a press
    // held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_q <= '0;
            arm_q      <= '0;
        end else begin
            btn_prev_q <= btn;
            arm_q      <= arm_q | (~btn & {NREG{fill}});
        end
    end

    assign act = btn & ~btn_prev_q & arm_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (regs_q[0]),
        .b      (regs_q[1]),
        .op     (alu_op),
        .result (alu_res),
        .carry  (alu_carry)
    );

    logic [WIDTH-1:0] src_val;

    always_comb begin
        src_val = '0;
        for (int j = 0; j < int'(NREG); j++) begin
            if (src_sel == SelW'(j)) begin
                src_val = regs_q[j];
            end
        end
    end

    // All targets read regs_q, so simultaneous actions see pre-update values.
    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        for (int k = 0; k < int'(NREG); k++) begin
            if (act[k]) begin
                if (mode == ModeXfer) begin
                    regs_d[k] = src_val;
                end else if (k == int'(NREG) - 1) begin
                    regs_d[k] = alu_res;
                    flags_d   = {alu_carry, alu_res == '0};
                end else if (dir[k]) begin
                    regs_d[k] = regs_q[k] - One;
                end else begin
                    regs_d[k] = regs_q[k] + One;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q  <= '{default: '0};
            flags_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
            upd_q   <= |act;
        end
    end

    for (genvar g = 0; g < int'(NREG); g++) begin : g_debug
        assign debug_reg[g*WIDTH +: WIDTH] = regs_q[g];
    end

    assign debug_res = regs_q[0] + regs_q[1];
    assign flags     = flags_q;
    assign upd       = upd_q;

endmodule
